spike_event_fifo: RTL and testbench
===================================

Name: spike_event_fifo

Overview:
- Downstream stage of the LIF neuron. Consumes the neuron's axon level and membrane voltage V.
- Converts each accepted spike into a timestamped event {ts, V} and buffers events in a FIFO.
- Presents buffered events on a valid/ready stream to the router or monitor.
- Applies a refractory hold-off and counts events dropped on overflow.

Parameters:
- TS_W, 16, timestamp counter width.
- DEPTH, 8, FIFO entries; must be a power of 2, at least 2.
- REFRACTORY, 2, cycles of hold-off after an accepted spike; 0 disables hold-off.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- axon  in  1  spike level from the LIF neuron.
- V  in  8  LIF membrane voltage, sampled with the spike.
- ev_ready  in  1  consumer accepts the head event.
- ev_valid  out  1  head event present.
- ev_ts  out  TS_W  timestamp of the head event.
- ev_v  out  8  V snapshot of the head event.
- fifo_count  out  $clog2(DEPTH)+1  current occupancy.
- drop_cnt  out  8  events lost to a full FIFO; saturates at 255.
- overflow  out  1  sticky flag, set on the first drop.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - ts=0, axon_q=0, refr_cnt=0.
  - FIFO emptied.
  - ev_valid=0, ev_ts=0, ev_v=0, fifo_count=0, drop_cnt=0, overflow=0.
- Timestamp: ts is a free-running counter. It increments every non-reset cycle and wraps from 2^TS_W-1 to 0 without a flag.
- Edge detect: axon_q is a register holding axon from the previous cycle. rise = axon & ~axon_q.
- Spike acceptance: spike_ok = rise & (refr_cnt==0).
  - The event payload is {ts, V} as they stand in the rise cycle, i.e. ts before its increment.
- Refractory:
  - spike_ok loads refr_cnt=REFRACTORY for the next cycle.
  - Otherwise refr_cnt decrements while non-zero.
  - A rise while refr_cnt!=0 is discarded silently. It is not a drop.
  - Result: the earliest next acceptance is REFRACTORY+1 cycles after an accepted spike.
- Sustained axon: a level held high produces one event only.
- Pop: pop = ev_valid & ev_ready. ev_valid = (fifo_count!=0).
  - ev_ts and ev_v show the head entry.
  - They stay stable while ev_valid & ~ev_ready.
- Push: push = spike_ok & (~full | pop). Full plus simultaneous pop means push and pop both occur, count unchanged, no drop.
- Drop: spike_ok & full & ~pop causes a drop.
  - drop_cnt increments, saturating at 255.
  - overflow is set and held until rst.
- Latency: a spike in cycle t into an empty FIFO gives ev_valid=1 in cycle t+1. There is no combinational bypass.
- Ordering: strict FIFO; timestamps leave in acceptance order.
- fifo_count: +1 on push only, -1 on pop only, unchanged on both or neither.
- Reset mid-operation:
  - All queued events are discarded and counters cleared.
  - axon_q clears, so axon=1 in the first cycle after reset counts as a rise with ts=0.
- Pointers: read and write pointers are $clog2(DEPTH) bits and wrap naturally.

Decomposition:
- Shared package lif_pkg holds:
  - V_W=8.
  - DROP_W=8.
  - Typedef spike_event_t {logic [TS_W-1:0] ts; logic [V_W-1:0] v;}. Width is parameterised through the package default.
- One sub-module, spike_sync_fifo: a generic synchronous FIFO with push/pop, full/empty and count.
- Edge detect, refractory counter, timestamp and drop logic stay in spike_event_fifo.

Test Plan:
- Reset, ev_ready=1, axon 0→1 at ts=5 with V=200 → ev_valid=1 next cycle, ev_ts=5, ev_v=200, popped; fifo_count returns to 0.
- axon held high 10 cycles from ts=20 → exactly one event (ts=20); drop_cnt=0.
- REFRACTORY=2, rises at ts=10, 12, 14 (axon toggling) → events ts=10 and ts=14 only; the rise at ts=12 is suppressed; drop_cnt=0.
- DEPTH=8, ev_ready=0, 10 acceptable spikes → fifo_count=8, drop_cnt=2, overflow=1. Then ev_ready=1 → 8 events drained in ascending ts order, overflow still 1.
- FIFO full, ev_ready=1 and spike in same cycle → no drop, fifo_count stays 8, new ts appears last when drained.
- TS_W=4, spikes at ts=15 and next at ts=1 after wrap → ev_ts=15 then 1. rst asserted with 3 queued events → next cycle ev_valid=0, fifo_count=0, drop_cnt=0, ts=0.

Source files
------------

// File: rtl/lif_pkg.sv
// Shared types, widths and helpers for the LIF spike event path.
package lif_pkg;

  localparam int V_W      = 8;
  localparam int DROP_W   = 8;
  localparam int TS_W_DEF = 16;

  // One buffered spike: timestamp of the rising edge plus the membrane voltage snapshot.
  typedef struct packed {
    logic [TS_W_DEF-1:0] ts;
    logic [V_W-1:0]      v;
  } spike_event_t;

  // Saturating increment for the drop counter; holds at all-ones.
  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] val);
    if (val == {DROP_W{1'b1}}) begin
      sat_inc = val;
    end else begin
      sat_inc = val + {{(DROP_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/spike_sync_fifo.sv
// Generic single-clock FIFO with occupancy count; head entry is always visible on dout.
module spike_sync_fifo
  import lif_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             push_s;
  logic             pop_s;

  // Qualify requests: never pop when empty, only push into a full FIFO when a pop frees a slot.
  always_comb begin
    pop_s  = pop & ~empty;
    push_s = push & (~full | pop_s);
  end

  // Storage, wrapping pointers and occupancy update.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign full  = (count_r == CW'(DEPTH));
  assign empty = (count_r == '0);
  assign count = count_r;

endmodule

// File: rtl/spike_event_fifo.sv
// Turns accepted axon rising edges into timestamped {ts, V} events and streams them out.
module spike_event_fifo
  import lif_pkg::*;
#(
  parameter int TS_W       = 16,
  parameter int DEPTH      = 8,
  parameter int REFRACTORY = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   axon,
  input  logic [7:0]             V,
  input  logic                   ev_ready,
  output logic                   ev_valid,
  output logic [TS_W-1:0]        ev_ts,
  output logic [7:0]             ev_v,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [7:0]             drop_cnt,
  output logic                   overflow
);

  localparam int RW = (REFRACTORY > 0) ? $clog2(REFRACTORY + 1) : 1;
  localparam int EW = TS_W + V_W;

  logic [TS_W-1:0]   ts_r;
  logic              axon_q_r;
  logic [RW-1:0]     refr_cnt_r;
  logic [DROP_W-1:0] drop_cnt_r;
  logic              overflow_r;

  logic              rise_s;
  logic              spike_ok_s;
  logic              pop_s;
  logic              push_s;
  logic              drop_s;
  logic              full_s;
  logic              empty_s;
  logic [EW-1:0]     head_s;

  // Edge detect, refractory gating and push/pop/drop decisions.
  always_comb begin
    rise_s     = axon & ~axon_q_r;
    spike_ok_s = rise_s & (refr_cnt_r == '0);
    pop_s      = ~empty_s & ev_ready;
    push_s     = spike_ok_s & (~full_s | pop_s);
    drop_s     = spike_ok_s & full_s & ~pop_s;
  end

  // Free-running timestamp and previous-cycle axon level.
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_r     <= '0;
      axon_q_r <= 1'b0;
    end else begin
      ts_r     <= ts_r + TS_W'(1);
      axon_q_r <= axon;
    end
  end

  // Refractory hold-off: reload on acceptance, then count down to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      refr_cnt_r <= '0;
    end else if (spike_ok_s) begin
      refr_cnt_r <= RW'(REFRACTORY);
    end else if (refr_cnt_r != '0) begin
      refr_cnt_r <= refr_cnt_r - RW'(1);
    end else begin
      refr_cnt_r <= refr_cnt_r;
    end
  end

  // Drop accounting: saturating count plus sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_r <= '0;
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      drop_cnt_r <= sat_inc(drop_cnt_r);
      overflow_r <= 1'b1;
    end else begin
      drop_cnt_r <= drop_cnt_r;
      overflow_r <= overflow_r;
    end
  end

  spike_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .din   ({ts_r, V}),
    .dout  (head_s),
    .full  (full_s),
    .empty (empty_s),
    .count (fifo_count)
  );

  assign ev_valid = ~empty_s;
  assign ev_ts    = head_s[EW-1:V_W];
  assign ev_v     = head_s[V_W-1:0];
  assign drop_cnt = drop_cnt_r;
  assign overflow = overflow_r;

endmodule

// File: tb/tb_spike_event_fifo.sv
// Self-checking bench for spike_event_fifo against a queue-based behavioural model.
module tb_spike_event_fifo;
  import lif_pkg::*;

  localparam int DEPTH = 8;
  localparam int REFR  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        axon;
  logic [7:0]  V;
  logic        ev_ready;
  logic        ev_valid;
  logic [15:0] ev_ts;
  logic [7:0]  ev_v;
  logic [3:0]  fifo_count;
  logic [7:0]  drop_cnt;
  logic        overflow;

  logic        axon4;
  logic [7:0]  v4;
  logic        ready4;
  logic        ev_valid4;
  logic [3:0]  ev_ts4;
  logic [7:0]  ev_v4;
  logic [3:0]  count4;
  logic [7:0]  drop4;
  logic        ovf4;

  spike_event_fifo #(.TS_W(16), .DEPTH(DEPTH), .REFRACTORY(REFR)) dut (
    .clk(clk), .rst(rst), .axon(axon), .V(V), .ev_ready(ev_ready),
    .ev_valid(ev_valid), .ev_ts(ev_ts), .ev_v(ev_v), .fifo_count(fifo_count),
    .drop_cnt(drop_cnt), .overflow(overflow)
  );

  spike_event_fifo #(.TS_W(4), .DEPTH(DEPTH), .REFRACTORY(0)) dut4 (
    .clk(clk), .rst(rst), .axon(axon4), .V(v4), .ev_ready(ready4),
    .ev_valid(ev_valid4), .ev_ts(ev_ts4), .ev_v(ev_v4), .fifo_count(count4),
    .drop_cnt(drop4), .overflow(ovf4)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  bit            prev_axon = 1'b0;
  int            last_acc = -1000;
  spike_event_t  mq[$];
  int            mdrops = 0;
  bit            movf = 1'b0;
  logic [15:0]   popped[$];

  // Advance one clock: record DUT pops, update the model from the current inputs.
  task automatic tick();
    bit           rise, ok, mpop, mfull;
    spike_event_t e;
    if (!rst && ev_valid && ev_ready) popped.push_back(ev_ts);
    rise  = axon && !prev_axon;
    ok    = rise && ((cyc - last_acc) > REFR);
    mpop  = (mq.size() > 0) && ev_ready;
    mfull = (mq.size() == DEPTH);
    if (mpop) void'(mq.pop_front());
    if (ok) begin
      last_acc = cyc;
      if (!mfull || mpop) begin
        e.ts = cyc[15:0];
        e.v  = V;
        mq.push_back(e);
      end else begin
        if (mdrops < 255) mdrops++;
        movf = 1'b1;
      end
    end
    if (rst) begin
      cyc = 0; prev_axon = 1'b0; last_acc = -1000;
      mq.delete(); mdrops = 0; movf = 1'b0;
    end else begin
      cyc++;
      prev_axon = axon;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; axon = 1'b0; ev_ready = 1'b0; V = 8'd0;
    axon4 = 1'b0; ready4 = 1'b0; v4 = 8'd0;
    tick(); tick();
    rst = 1'b0;
    popped.delete();
  endtask

  task automatic advance_to(input int t);
    for (int k = 0; k < 1000 && cyc < t; k++) tick();
  endtask

  // One isolated spike pulse followed by quiet cycles longer than the hold-off.
  task automatic pulse(output logic [15:0] ts_out);
    ts_out = cyc[15:0];
    axon = 1'b1; V = 8'($urandom);
    tick();
    axon = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0d expected 0", ev_valid); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
    checks++; if (drop_cnt !== 8'd0 || overflow !== 1'b0) begin errors++; $display("FAIL reset_drop: got %0d/%0d expected 0/0", drop_cnt, overflow); end
    checks++; if (ev_ts !== 16'd0 || ev_v !== 8'd0) begin errors++; $display("FAIL reset_head: got ts %0d v %0d expected 0 0", ev_ts, ev_v); end
    checks++; if (ev_valid4 !== 1'b0 || count4 !== 4'd0) begin errors++; $display("FAIL reset_dut4: got %0d/%0d expected 0/0", ev_valid4, count4); end
  endtask

  task automatic test_single();
    do_reset();
    ev_ready = 1'b1;
    advance_to(5);
    axon = 1'b1; V = 8'd200;
    tick();
    checks++; if (ev_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %0d expected 1", ev_valid); end
    checks++; if (ev_ts !== 16'd5 || ev_v !== 8'd200) begin errors++; $display("FAIL single_head: got ts %0d v %0d expected 5 200", ev_ts, ev_v); end
    axon = 1'b0;
    tick();
    checks++; if (popped.size() != 1 || popped[0] !== 16'd5) begin errors++; $display("FAIL single_pop: got %0d pops expected 1 at ts 5", popped.size()); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL single_count: got %0d expected 0", fifo_count); end
  endtask

  task automatic test_sustain();
    do_reset();
    ev_ready = 1'b1;
    advance_to(20);
    axon = 1'b1; V = 8'd77;
    repeat (10) tick();
    axon = 1'b0;
    repeat (3) tick();
    checks++; if (popped.size() != 1) begin errors++; $display("FAIL sustain_events: got %0d expected 1", popped.size()); end
    checks++; if (popped.size() > 0 && popped[0] !== 16'd20) begin errors++; $display("FAIL sustain_ts: got %0d expected 20", popped[0]); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL sustain_drop: got %0d expected 0", drop_cnt); end
  endtask

  task automatic test_refractory();
    do_reset();
    ev_ready = 1'b1;
    advance_to(10);
    for (int i = 0; i < 5; i++) begin
      axon = ((i % 2) == 0);
      tick();
    end
    axon = 1'b0;
    repeat (3) tick();
    checks++; if (popped.size() != 2) begin errors++; $display("FAIL refr_events: got %0d expected 2", popped.size()); end
    checks++; if (popped.size() == 2 && (popped[0] !== 16'd10 || popped[1] !== 16'd14)) begin errors++; $display("FAIL refr_ts: got %0d,%0d expected 10,14", popped[0], popped[1]); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL refr_drop: got %0d expected 0", drop_cnt); end
  endtask

  task automatic test_overflow();
    logic [15:0] exp_ts[$];
    logic [15:0] t;
    do_reset();
    repeat (10) begin
      pulse(t);
      exp_ts.push_back(t);
    end
    checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL ovf_count: got %0d expected 8", fifo_count); end
    checks++; if (drop_cnt !== 8'd2) begin errors++; $display("FAIL ovf_drops: got %0d expected 2", drop_cnt); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %0d expected 1", overflow); end
    ev_ready = 1'b1;
    repeat (10) tick();
    checks++; if (popped.size() != 8) begin errors++; $display("FAIL ovf_drain: got %0d expected 8", popped.size()); end
    for (int i = 0; i < 8 && i < popped.size(); i++) begin
      checks++; if (popped[i] !== exp_ts[i]) begin errors++; $display("FAIL ovf_order[%0d]: got %0d expected %0d", i, popped[i], exp_ts[i]); end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %0d expected 1", overflow); end
  endtask

  task automatic test_full_pop();
    logic [15:0] t;
    logic [15:0] last_ts;
    do_reset();
    repeat (8) pulse(t);
    last_ts = cyc[15:0];
    axon = 1'b1; ev_ready = 1'b1; V = 8'd9;
    tick();
    checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL fullpop_count: got %0d expected 8", fifo_count); end
    checks++; if (drop_cnt !== 8'd0 || overflow !== 1'b0) begin errors++; $display("FAIL fullpop_drop: got %0d/%0d expected 0/0", drop_cnt, overflow); end
    axon = 1'b0;
    repeat (12) tick();
    checks++; if (popped.size() != 9 || popped[8] !== last_ts) begin errors++; $display("FAIL fullpop_last: got %0d pops expected 9 ending at ts %0d", popped.size(), last_ts); end
  endtask

  task automatic test_wrap();
    do_reset();
    advance_to(15);
    axon4 = 1'b1; tick();
    axon4 = 1'b0; tick();
    axon4 = 1'b1; tick();
    axon4 = 1'b0; tick();
    checks++; if (count4 !== 4'd2) begin errors++; $display("FAIL wrap_count: got %0d expected 2", count4); end
    checks++; if (ev_ts4 !== 4'd15) begin errors++; $display("FAIL wrap_first: got %0d expected 15", ev_ts4); end
    ready4 = 1'b1; tick(); ready4 = 1'b0;
    checks++; if (ev_valid4 !== 1'b1 || ev_ts4 !== 4'd1) begin errors++; $display("FAIL wrap_second: got valid %0d ts %0d expected 1 1", ev_valid4, ev_ts4); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] t;
    do_reset();
    repeat (3) pulse(t);
    checks++; if (fifo_count !== 4'd3) begin errors++; $display("FAIL rmid_fill: got %0d expected 3", fifo_count); end
    rst = 1'b1; axon = 1'b1;
    tick();
    checks++; if (ev_valid !== 1'b0 || fifo_count !== 4'd0 || drop_cnt !== 8'd0) begin errors++; $display("FAIL rmid_clear: got %0d/%0d/%0d expected 0/0/0", ev_valid, fifo_count, drop_cnt); end
    rst = 1'b0; V = 8'd33;
    tick();
    checks++; if (ev_valid !== 1'b1 || ev_ts !== 16'd0 || ev_v !== 8'd33) begin errors++; $display("FAIL rmid_first: got valid %0d ts %0d v %0d expected 1 0 33", ev_valid, ev_ts, ev_v); end
    axon = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst      = (i == 250);
      axon     = $urandom_range(0, 1) == 1;
      V        = 8'($urandom);
      ev_ready = (i < 120) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 3) != 0);
      tick();
      checks++; if (fifo_count !== 4'(mq.size())) begin errors++; $display("FAIL rnd_count@%0d: got %0d expected %0d", i, fifo_count, mq.size()); end
      checks++; if (ev_valid !== (mq.size() != 0)) begin errors++; $display("FAIL rnd_valid@%0d: got %0d expected %0d", i, ev_valid, mq.size() != 0); end
      if (mq.size() != 0) begin
        checks++; if (ev_ts !== mq[0].ts || ev_v !== mq[0].v) begin errors++; $display("FAIL rnd_head@%0d: got %0d/%0d expected %0d/%0d", i, ev_ts, ev_v, mq[0].ts, mq[0].v); end
      end
      checks++; if (drop_cnt !== 8'(mdrops) || overflow !== movf) begin errors++; $display("FAIL rnd_drop@%0d: got %0d/%0d expected %0d/%0d", i, drop_cnt, overflow, mdrops, movf); end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_sustain();
    test_refractory();
    test_overflow();
    test_full_pop();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
